// File: rtl/i2c_master.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master
// Brief    : Byte-level I2C master. Sequences START, WRITE/READ with ACK, STOP.
// Revision : 1.0
// ============================================================================
module i2c_master #(
  parameter logic [15:0] DEFAULT_PRESCALE = 16'd250
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [1:0]  i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        I2C_SCL,
  inout  wire         I2C_SDA
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BIT   = 3'd2,
    ST_ACK   = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_q, w_q_nxt;
  logic [2:0]  r_bit, w_bit_nxt;
  logic [15:0] r_cnt, r_prescale, w_period;
  logic [7:0]  r_tx, r_rx;
  logic [1:0]  r_sda_sync;
  logic        r_nack, r_bus_active, r_scl, r_sda_low, r_ready;
  logic [31:0] r_rdata;
  logic        r_do_write, r_do_read, r_do_stop, r_nack_on_read;
  logic        w_do_write_nxt, w_do_read_nxt, w_do_stop_nxt, w_nack_on_read_nxt;
  logic        w_scl_nxt, w_sda_low_nxt;
  logic        w_busy, w_tick, w_wr, w_accept;
  logic        w_unused;

  assign w_busy   = (r_state != ST_IDLE);
  assign w_period = (r_prescale < 16'd4) ? 16'd4 : r_prescale;
  assign w_tick   = w_busy && (r_cnt == w_period - 16'd1);
  assign w_wr     = i_request && i_rw && !w_busy;
  assign w_accept = w_wr && (i_address == 2'd1) && (i_wdata[3:0] != 4'd0);
  assign w_unused = ^i_wdata[31:16];

  assign w_do_write_nxt     = w_accept ? i_wdata[2] : r_do_write;
  assign w_do_read_nxt      = w_accept ? (i_wdata[3] && !i_wdata[2]) : r_do_read;
  assign w_do_stop_nxt      = w_accept ? i_wdata[1] : r_do_stop;
  assign w_nack_on_read_nxt = w_accept ? i_wdata[4] : r_nack_on_read;

  assign o_rdata = r_rdata;
  assign o_ready = r_ready;
  assign I2C_SCL = r_scl;
  assign I2C_SDA = r_sda_low ? 1'b0 : 1'bz;

  // Next state, then pin levels decoded from the next state so pins stay registered
  always_comb begin
    w_state_nxt   = r_state;
    w_q_nxt       = r_q;
    w_bit_nxt     = r_bit;
    w_scl_nxt     = r_scl;
    w_sda_low_nxt = 1'b0;
    if (w_accept) begin
      w_q_nxt   = 2'd0;
      w_bit_nxt = 3'd7;
      if (i_wdata[0])                    w_state_nxt = ST_START;
      else if (i_wdata[2] || i_wdata[3]) w_state_nxt = ST_BIT;
      else                               w_state_nxt = ST_STOP;
    end else if (w_tick) begin
      w_q_nxt = r_q + 2'd1;
      if (r_q == 2'd3) begin
        case (r_state)
          ST_START: begin
            w_bit_nxt = 3'd7;
            if (r_do_write || r_do_read) w_state_nxt = ST_BIT;
            else if (r_do_stop)          w_state_nxt = ST_STOP;
            else                         w_state_nxt = ST_IDLE;
          end
          ST_BIT: begin
            if (r_bit == 3'd0) w_state_nxt = ST_ACK;
            else               w_bit_nxt   = r_bit - 3'd1;
          end
          ST_ACK:  w_state_nxt = r_do_stop ? ST_STOP : ST_IDLE;
          default: w_state_nxt = ST_IDLE;
        endcase
      end
    end

    case (w_state_nxt)
      ST_START: begin
        w_scl_nxt     = (w_q_nxt != 2'd3);
        w_sda_low_nxt = (w_q_nxt != 2'd0);
      end
      ST_BIT: begin
        w_scl_nxt     = (w_q_nxt == 2'd1) || (w_q_nxt == 2'd2);
        w_sda_low_nxt = w_do_write_nxt && !r_tx[w_bit_nxt];
      end
      ST_ACK: begin
        w_scl_nxt     = (w_q_nxt == 2'd1) || (w_q_nxt == 2'd2);
        w_sda_low_nxt = !w_do_write_nxt && !w_nack_on_read_nxt;
      end
      ST_STOP: begin
        w_scl_nxt     = (w_q_nxt != 2'd0);
        w_sda_low_nxt = (w_q_nxt <= 2'd1);
      end
      default: begin
        w_scl_nxt     = r_scl;
        w_sda_low_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_q     <= 2'd0;
      r_bit   <= 3'd7;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_bit   <= w_bit_nxt;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt          <= 16'd0;
      r_prescale     <= DEFAULT_PRESCALE;
      r_tx           <= 8'd0;
      r_rx           <= 8'd0;
      r_nack         <= 1'b0;
      r_bus_active   <= 1'b0;
      r_scl          <= 1'b1;
      r_sda_low      <= 1'b0;
      r_sda_sync     <= 2'b11;
      r_ready        <= 1'b0;
      r_rdata        <= 32'd0;
      r_do_write     <= 1'b0;
      r_do_read      <= 1'b0;
      r_do_stop      <= 1'b0;
      r_nack_on_read <= 1'b0;
    end else begin
      r_scl          <= w_scl_nxt;
      r_sda_low      <= w_sda_low_nxt;
      r_sda_sync     <= {r_sda_sync[0], I2C_SDA};
      r_ready        <= i_request;
      r_do_write     <= w_do_write_nxt;
      r_do_read      <= w_do_read_nxt;
      r_do_stop      <= w_do_stop_nxt;
      r_nack_on_read <= w_nack_on_read_nxt;

      if (w_accept || w_tick || !w_busy) r_cnt <= 16'd0;
      else                               r_cnt <= r_cnt + 16'd1;

      if (w_tick && (r_q == 2'd2)) begin
        if (r_state == ST_BIT && !r_do_write) r_rx[r_bit] <= r_sda_sync[1];
        if (r_state == ST_ACK && r_do_write)  r_nack      <= r_sda_sync[1];
      end
      if (w_tick && (r_q == 2'd3)) begin
        if (r_state == ST_START) r_bus_active <= 1'b1;
        if (r_state == ST_STOP)  r_bus_active <= 1'b0;
      end

      if (w_wr && i_address == 2'd0) r_tx       <= i_wdata[7:0];
      if (w_wr && i_address == 2'd2) r_prescale <= i_wdata[15:0];

      if (i_request && !i_rw) begin
        case (i_address)
          2'd0:    r_rdata <= {24'd0, r_rx};
          2'd1:    r_rdata <= {29'd0, r_bus_active, r_nack, w_busy};
          2'd2:    r_rdata <= {16'd0, r_prescale};
          default: r_rdata <= 32'd0;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_master
// Brief    : Self-checking bench for i2c_master with a behavioural I2C slave.
// Revision : 1.0
// ============================================================================
module tb_i2c_master;

  logic        clk = 1'b0;
  logic        rst_n, req, rw;
  logic [1:0]  addr;
  logic [31:0] wdata, rdata;
  logic        ready, scl;
  wire         sda;
  logic        slave_low = 1'b0;

  assign sda = slave_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_master #(.DEFAULT_PRESCALE(16'd250)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_request(req), .i_rw(rw),
    .i_address(addr), .i_wdata(wdata), .o_rdata(rdata), .o_ready(ready),
    .I2C_SCL(scl), .I2C_SDA(sda)
  );

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model of the register-visible state
  logic [15:0] m_prescale = 16'd250;
  logic [7:0]  m_tx = 8'd0, m_rx = 8'd0;
  logic        m_active = 1'b0, m_nack = 1'b0;

  // slave: drives a slot's bit after each SCL fall; a START restarts slot count
  logic        slave_on = 1'b0, slave_rd = 1'b0, slave_ack = 1'b0;
  logic [7:0]  slave_byte = 8'd0;
  int          rise_cnt = 0, starts = 0, stops = 0;
  logic        q_bits[$];

  function automatic logic slot_drive(input int slot);
    if (!slave_on || slot > 8) return 1'b0;
    if (slave_rd) return (slot < 8) ? !slave_byte[3'(7 - slot)] : 1'b0;
    return (slot == 8) ? slave_ack : 1'b0;
  endfunction

  always @(negedge scl) slave_low = slot_drive(rise_cnt);
  always @(posedge scl) begin rise_cnt++; q_bits.push_back(sda); end
  always @(negedge sda) if (scl === 1'b1) begin starts++; rise_cnt = 0; q_bits.delete(); end
  always @(posedge sda) if (scl === 1'b1) stops++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int eff(input logic [15:0] p);
    return (p < 16'd4) ? 4 : int'(p);
  endfunction

  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d, output logic [31:0] r);
    @(negedge clk);
    req = 1'b1; rw = w; addr = a; wdata = d;
    @(negedge clk);
    check("ready", {31'd0, ready}, 32'd1);
    r = rdata;
    req = 1'b0;
  endtask

  task automatic issue(input logic [4:0] c, output int c0);
    logic [31:0] r;
    bus(1'b1, 2'd1, {27'd0, c}, r);
    c0 = cyc;
  endtask

  // must be entered on a falling clock edge; status reads issued every cycle
  task automatic wait_idle(input int c0, output int len);
    int guard = 0;
    req = 1'b1; rw = 1'b0; addr = 2'd1;
    forever begin
      @(negedge clk);
      if (rdata[0] == 1'b0) break;
      guard++;
      if (guard > 20000) begin
        vectors++; miscompares++;
        $display("FAIL busy_timeout: got busy still 1 expected 0");
        break;
      end
    end
    len = cyc - c0 - 1;
    req = 1'b0;
  endtask

  task automatic arm(input logic rd, input logic ack, input logic [7:0] b, input logic has_start);
    slave_on = 1'b1; slave_rd = rd; slave_ack = ack; slave_byte = b;
    rise_cnt = 0; starts = 0; stops = 0; q_bits.delete();
    slave_low = has_start ? 1'b0 : slot_drive(0);
  endtask

  task automatic check_bits(input string tag, input logic e[$]);
    logic [15:0] av, ev;
    av = 16'd0; ev = 16'd0;
    foreach (q_bits[i]) av = {av[14:0], q_bits[i]};
    foreach (e[i]) ev = {ev[14:0], e[i]};
    check({tag, " bits"}, {8'(q_bits.size()), 8'd0, av}, {8'(e.size()), 8'd0, ev});
  endtask

  task automatic expect_bits(input logic [4:0] c, input logic sack, input logic [7:0] sb, output logic e[$]);
    e.delete();
    if (c[2]) begin
      for (int i = 7; i >= 0; i--) e.push_back(m_tx[i]);
      e.push_back(!sack);
    end else if (c[3]) begin
      for (int i = 7; i >= 0; i--) e.push_back(sb[i]);
      e.push_back(c[4]);
    end
    if (c[1]) e.push_back(1'b0);
  endtask

  task automatic update_model(input logic [4:0] c, input logic sack, input logic [7:0] sb);
    if (c[2])      m_nack = !sack;
    else if (c[3]) m_rx = sb;
    if (c[1])      m_active = 1'b0;
    else if (c[0]) m_active = 1'b1;
  endtask

  task automatic run_cmd(input string tag, input logic [4:0] c, input logic sack,
                         input logic [7:0] sb, input logic chk_cond);
    int c0, len, steps;
    logic [31:0] r;
    logic e[$];
    steps = (c[0] ? 1 : 0) + ((c[2] || c[3]) ? 9 : 0) + (c[1] ? 1 : 0);
    expect_bits(c, sack, sb, e);
    arm(c[3] && !c[2], sack, sb, c[0]);
    issue(c, c0);
    wait_idle(c0, len);
    check({tag, " busy"}, 32'(len), 32'(4 * eff(m_prescale) * steps));
    check_bits(tag, e);
    if (chk_cond) begin
      check({tag, " starts"}, 32'(starts), {31'd0, c[0]});
      check({tag, " stops"}, 32'(stops), {31'd0, c[1]});
    end
    slave_on = 1'b0; slave_low = 1'b0;
    update_model(c, sack, sb);
    bus(1'b0, 2'd1, 32'd0, r);
    check({tag, " status"}, r, {29'd0, m_active, m_nack, 1'b0});
    bus(1'b0, 2'd0, 32'd0, r);
    check({tag, " rx"}, r, {24'd0, m_rx});
  endtask

  typedef struct packed {
    logic        rw;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[14];

  initial begin
    logic [31:0] r;
    logic        e[$];
    int          c0, len;

    tbl[0]  = {1'b0, 2'd1, 32'd0,          32'd0};
    tbl[1]  = {1'b0, 2'd2, 32'd0,          32'd250};
    tbl[2]  = {1'b0, 2'd0, 32'd0,          32'd0};
    tbl[3]  = {1'b0, 2'd3, 32'd0,          32'd0};
    tbl[4]  = {1'b1, 2'd3, 32'hFFFF_FFFF,  32'd0};
    tbl[5]  = {1'b1, 2'd2, 32'h1234_ABCD,  32'd0};
    tbl[6]  = {1'b0, 2'd2, 32'd0,          32'h0000_ABCD};
    tbl[7]  = {1'b0, 2'd3, 32'd0,          32'd0};
    tbl[8]  = {1'b1, 2'd2, 32'd1,          32'd0};
    tbl[9]  = {1'b0, 2'd2, 32'd0,          32'd1};
    tbl[10] = {1'b1, 2'd0, 32'h0000_01A5,  32'd0};
    tbl[11] = {1'b0, 2'd0, 32'd0,          32'd0};
    tbl[12] = {1'b1, 2'd1, 32'd0,          32'd0};
    tbl[13] = {1'b0, 2'd1, 32'd0,          32'd0};

    rst_n = 1'b0; req = 1'b0; rw = 1'b0; addr = 2'd0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    check("reset scl", {31'd0, scl}, 32'd1);
    check("reset sda", {31'd0, sda}, 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      bus(tbl[i].rw, tbl[i].addr, tbl[i].wdata, r);
      if (!tbl[i].rw) check($sformatf("table[%0d]", i), r, tbl[i].exp);
    end
    m_prescale = 16'd1;
    m_tx = 8'hA5;

    // prescale 1 is clamped to 4; a CMD with no action bits never goes busy
    run_cmd("clamp", 5'h01, 1'b0, 8'h00, 1'b1);
    run_cmd("noop", 5'h00, 1'b0, 8'h00, 1'b0);
    run_cmd("noop_nor", 5'h10, 1'b0, 8'h00, 1'b0);

    bus(1'b1, 2'd2, 32'd4, r); m_prescale = 16'd4;
    run_cmd("wr_ack", 5'h07, 1'b1, 8'h00, 1'b1);
    run_cmd("start_only", 5'h01, 1'b0, 8'h00, 1'b1);
    run_cmd("rd_nack", 5'h1A, 1'b0, 8'h3C, 1'b1);

    // no slave ACK, with register writes attempted mid-transfer
    expect_bits(5'h07, 1'b0, 8'h00, e);
    arm(1'b0, 1'b0, 8'h00, 1'b1);
    issue(5'h07, c0);
    repeat (20) @(negedge clk);
    bus(1'b1, 2'd0, 32'h0000_00FF, r);
    bus(1'b1, 2'd1, 32'h0000_0001, r);
    bus(1'b1, 2'd2, 32'h0000_0009, r);
    wait_idle(c0, len);
    check("busywr busy", 32'(len), 32'd176);
    check_bits("busywr", e);
    slave_on = 1'b0; slave_low = 1'b0;
    update_model(5'h07, 1'b0, 8'h00);
    bus(1'b0, 2'd1, 32'd0, r);
    check("nack status", r, 32'd2);
    bus(1'b0, 2'd2, 32'd0, r);
    check("prescale kept", r, 32'd4);
    run_cmd("tx_kept", 5'h04, 1'b1, 8'h00, 1'b0);

    for (int i = 0; i < 16; i++) begin
      logic [4:0] c;
      logic       sack;
      logic [7:0] sb;
      m_prescale = 16'($urandom_range(0, 6));
      bus(1'b1, 2'd2, {16'd0, m_prescale}, r);
      m_tx = 8'($urandom_range(0, 255));
      bus(1'b1, 2'd0, {24'd0, m_tx}, r);
      c    = 5'($urandom_range(0, 31));
      sack = 1'($urandom_range(0, 1));
      sb   = 8'($urandom_range(0, 255));
      run_cmd($sformatf("rand%0d c=%0h", i, c), c, sack, sb, 1'b0);
    end

    // reset in the middle of a write releases both lines immediately
    bus(1'b1, 2'd2, 32'd4, r);
    bus(1'b1, 2'd0, 32'h0000_0000, r);
    arm(1'b0, 1'b1, 8'h00, 1'b1);
    issue(5'h07, c0);
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    slave_on = 1'b0; slave_low = 1'b0;
    #1;
    check("midrst scl", {31'd0, scl}, 32'd1);
    check("midrst sda", {31'd0, sda}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus(1'b0, 2'd1, 32'd0, r);
    check("midrst status", r, 32'd0);
    bus(1'b0, 2'd2, 32'd0, r);
    check("midrst prescale", r, 32'd250);
    bus(1'b0, 2'd0, 32'd0, r);
    check("midrst rx", r, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
